cfg_reg_file: RTL and testbench
===============================

CFG_REG_FILE -- requirements
Module: cfg_reg_file

Interface
REQ-001 SHALL have parameter WIDTH, default 8, register data width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, number of registers (2..256; need not be a power of two).
REQ-003 SHALL have parameter RO_MASK, default 16'h000C, DEPTH bits; bit i=1 makes register i bus-read-only.
REQ-004 SHALL have parameter RST_VAL, default {8'h20,8'h43,8'h00,8'h00}, reset values for registers 3..0 (MSB = reg 3); all other registers reset to 0.
REQ-005 SHALL have parameter NUM_EXP, default 4, number of registers exported as direct outputs (1..DEPTH).
REQ-006 SHALL have parameter RD_LAT, default 1, read latency in cycles (1 or 2).
REQ-007 SHALL derive AW = max(1, $clog2(DEPTH)) as the address width.
REQ-008 CLK  in  1  single clock; all state changes on its rising edge.
REQ-009 RST_n  in  1  reset; asynchronous and active-low.
REQ-010 WrEn  in  1  write request, sampled each rising edge.
REQ-011 RdEn  in  1  read request, sampled each rising edge.
REQ-012 Address  in  AW  register index.
REQ-013 WrData  in  WIDTH  write data.
REQ-014 RdData  out  WIDTH  read data, meaningful when RdData_Valid=1.
REQ-015 RdData_Valid  out  1  one-cycle pulse per accepted read.
REQ-016 Err  out  1  one-cycle pulse per rejected access.
REQ-017 REG_OUT  out  NUM_EXP*WIDTH  registers NUM_EXP-1..0 concatenated; register 0 occupies bits [WIDTH-1:0].
REQ-018 Cfg_Changed  out  NUM_EXP  bit i pulses for one cycle when exported register i changes value.

Function
REQ-019 SHALL give WrEn priority when WrEn=RdEn=1: the write is processed, the read is dropped, no RdData_Valid and no Err for the dropped read.
REQ-020 SHALL accept a write when Address<DEPTH and RO_MASK[Address]=0: register updates at that edge.
REQ-021 SHALL reject a write when Address>=DEPTH or RO_MASK[Address]=1: no register changes; Err=1 in the following cycle.
REQ-022 SHALL accept a read when RdEn=1, WrEn=0 and Address<DEPTH; read-only registers are readable.
REQ-023 SHALL present the register contents sampled at the accepting edge on RdData, with RdData_Valid=1, exactly RD_LAT cycles after that edge.
REQ-024 SHALL reject a read with Address>=DEPTH: Err pulses one cycle later, no RdData_Valid, RdData unchanged.
REQ-025 SHALL hold RdData at its last valid value while RdData_Valid=0.
REQ-026 SHALL support back-to-back reads every cycle at full throughput for RD_LAT=2, with results returned in issue order.
REQ-027 SHALL return pre-write data for a read accepted one cycle before a write to the same address, even when RD_LAT=2.
REQ-028 SHALL drive REG_OUT combinationally from register state, so a write is visible on REG_OUT in the cycle after the write edge.
REQ-029 SHALL pulse Cfg_Changed[i] in the cycle REG_OUT shows the new value, only when an accepted write changes register i; writing an identical value gives no pulse.
REQ-030 SHALL never assert RdData_Valid and Err in the same cycle for the same request.

Reset
REQ-031 SHALL, on RST_n=0 and regardless of CLK, set registers 0..3 from RST_VAL, all others to 0, RdData=0, RdData_Valid=0, Err=0, Cfg_Changed=0.
REQ-032 SHALL, on reset mid-operation, discard any in-flight read, with no RdData_Valid after reset release.
REQ-033 SHALL apply the first write or read at the first rising edge with RST_n=1.

Verification
REQ-034 Reset, then read addresses 0..3 with RD_LAT=1 -> RdData 00,00,43,20, each with a one-cycle RdData_Valid one cycle after request; REG_OUT=32'h20430000.
REQ-035 Write 8'h32 to address 3 (read-only) -> Err pulses once, register 3 stays 8'h20, no Cfg_Changed; write 8'h46 to address 7 then read 7 -> RdData 8'h46.
REQ-036 Write 8'h3C to address 1 -> Cfg_Changed=4'b0010 for one cycle and REG_OUT[15:8]=8'h3C; repeat the same write -> no pulse.
REQ-037 WrEn=RdEn=1 with address 5 and data 8'hA5 -> register 5=8'hA5, no RdData_Valid that cycle; next read of 5 -> 8'hA5.
REQ-038 DEPTH=12, RD_LAT=2: read addresses 4,5,6 back-to-back after writing 04,05,06 -> data 04,05,06 valid on three consecutive cycles starting 2 cycles after the first request; read address 13 -> Err only.
REQ-039 Assert RST_n=0 between a read request and its return (RD_LAT=2) -> no RdData_Valid after release; registers back at RST_VAL.

Source files
------------

// File: rtl/cfg_reg_file.sv
// Configuration register file: parameterised depth, per-register read-only mask,
// directly exported low registers with change strobes, and 1- or 2-cycle reads.
module cfg_reg_file #(
  parameter int                  WIDTH   = 8,
  parameter int                  DEPTH   = 16,
  parameter logic [DEPTH-1:0]    RO_MASK = 16'h000C,
  parameter logic [4*WIDTH-1:0]  RST_VAL = {8'h20, 8'h43, 8'h00, 8'h00},
  parameter int                  NUM_EXP = 4,
  parameter int                  RD_LAT  = 1,
  localparam int                 AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                     CLK,
  input  logic                     RST_n,
  input  logic                     WrEn,
  input  logic                     RdEn,
  input  logic [AW-1:0]            Address,
  input  logic [WIDTH-1:0]         WrData,
  output logic [WIDTH-1:0]         RdData,
  output logic                     RdData_Valid,
  output logic                     Err,
  output logic [NUM_EXP*WIDTH-1:0] REG_OUT,
  output logic [NUM_EXP-1:0]       Cfg_Changed
);

  // Reset image padded so every register index has a slice, even when DEPTH < 4.
  localparam int                    RP      = (DEPTH > 4) ? DEPTH : 4;
  localparam logic [RP*WIDTH-1:0]   RST_PAD = (RP*WIDTH)'(RST_VAL);

  logic [WIDTH-1:0]   r_regs [DEPTH];
  logic [NUM_EXP-1:0] r_chg;
  logic [WIDTH-1:0]   r_rdata;
  logic               r_vld;
  logic               r_err;

  logic               w_hit;
  logic               w_ro;
  logic [WIDTH-1:0]   w_rd_word;
  logic [DEPTH-1:0]   w_sel;
  logic               w_wr_ok;
  logic               w_rd_ok;
  logic               w_err;
  logic               w_ret_vld;
  logic [WIDTH-1:0]   w_ret_data;

  // Decode by equality against each index so non-power-of-two depths never index past the array.
  always_comb begin
    w_hit     = 1'b0;
    w_ro      = 1'b0;
    w_rd_word = '0;
    w_sel     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (Address == AW'(i)) begin
        w_hit     = 1'b1;
        w_ro      = RO_MASK[i];
        w_rd_word = r_regs[i];
        w_sel[i]  = 1'b1;
      end
    end
  end

  assign w_wr_ok = WrEn & w_hit & ~w_ro;
  assign w_rd_ok = RdEn & ~WrEn & w_hit;
  assign w_err   = (WrEn & ~w_wr_ok) | (RdEn & ~WrEn & ~w_hit);

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= RST_PAD[i*WIDTH +: WIDTH];
    end else if (w_wr_ok) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_sel[i]) r_regs[i] <= WrData;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_chg <= '0;
    end else begin
      for (int i = 0; i < NUM_EXP; i++) begin
        r_chg[i] <= w_wr_ok & w_sel[i] & (WrData != r_regs[i]);
      end
    end
  end

  // Read data is captured at the accepting edge, so a later write cannot leak into it.
  generate
    if (RD_LAT == 2) begin : g_lat2
      logic             r_s1_vld;
      logic [WIDTH-1:0] r_s1_data;
      always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
          r_s1_vld  <= 1'b0;
          r_s1_data <= '0;
        end else begin
          r_s1_vld <= w_rd_ok;
          if (w_rd_ok) r_s1_data <= w_rd_word;
        end
      end
      assign w_ret_vld  = r_s1_vld;
      assign w_ret_data = r_s1_data;
    end else begin : g_lat1
      assign w_ret_vld  = w_rd_ok;
      assign w_ret_data = w_rd_word;
    end
  endgenerate

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_vld   <= 1'b0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_vld <= w_ret_vld;
      r_err <= w_err;
      if (w_ret_vld) r_rdata <= w_ret_data;
    end
  end

  generate
    for (genvar g = 0; g < NUM_EXP; g++) begin : g_exp
      assign REG_OUT[g*WIDTH +: WIDTH] = r_regs[g];
    end
  endgenerate

  assign RdData       = r_rdata;
  assign RdData_Valid = r_vld;
  assign Err          = r_err;
  assign Cfg_Changed  = r_chg;

endmodule

// File: tb/tb_cfg_reg_file.sv
// Bench for cfg_reg_file: instance A uses defaults (RD_LAT=1), instance B uses DEPTH=12, RD_LAT=2.
// Expected read/error returns are queued with their due cycle and checked by per-instance monitors.
module tb_cfg_reg_file;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        a_wr, a_rd;
  logic [3:0]  a_addr;
  logic [7:0]  a_wd, a_rdata;
  logic        a_vld, a_err;
  logic [31:0] a_regout;
  logic [3:0]  a_chg;

  logic        b_wr, b_rd;
  logic [3:0]  b_addr;
  logic [7:0]  b_wd, b_rdata;
  logic        b_vld, b_err;
  logic [31:0] b_regout;
  logic [3:0]  b_chg;

  cfg_reg_file u_a (
    .CLK(clk), .RST_n(rst_n), .WrEn(a_wr), .RdEn(a_rd), .Address(a_addr), .WrData(a_wd),
    .RdData(a_rdata), .RdData_Valid(a_vld), .Err(a_err), .REG_OUT(a_regout), .Cfg_Changed(a_chg)
  );

  cfg_reg_file #(.DEPTH(12), .RO_MASK(12'h00C), .RD_LAT(2)) u_b (
    .CLK(clk), .RST_n(rst_n), .WrEn(b_wr), .RdEn(b_rd), .Address(b_addr), .WrData(b_wd),
    .RdData(b_rdata), .RdData_Valid(b_vld), .Err(b_err), .REG_OUT(b_regout), .Cfg_Changed(b_chg)
  );

  typedef struct {
    int         cyc;
    bit         err;
    logic [7:0] data;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic [7:0] ma [16];
  logic [7:0] mb [12];

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  always @(negedge clk) begin
    if (rst_n) begin
      while (qa.size() > 0 && qa[0].cyc < cyc) begin
        n_checks++; n_fail++;
        $display("FAIL a_missing_output due_cyc=%0d now=%0d", qa[0].cyc, cyc);
        ea = qa.pop_front();
      end
      if (a_vld || a_err) begin
        n_checks++;
        if (qa.size() == 0) begin
          n_fail++;
          $display("FAIL a_unexpected_output cyc=%0d vld=%0b err=%0b data=%h required none", cyc, a_vld, a_err, a_rdata);
        end else begin
          ea = qa.pop_front();
          if (ea.cyc != cyc || a_err !== ea.err || a_vld !== !ea.err || (!ea.err && a_rdata !== ea.data)) begin
            n_fail++;
            $display("FAIL a_return cyc=%0d vld=%0b err=%0b data=%h required cyc=%0d err=%0b data=%h",
                     cyc, a_vld, a_err, a_rdata, ea.cyc, ea.err, ea.data);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      while (qb.size() > 0 && qb[0].cyc < cyc) begin
        n_checks++; n_fail++;
        $display("FAIL b_missing_output due_cyc=%0d now=%0d", qb[0].cyc, cyc);
        eb = qb.pop_front();
      end
      if (b_vld || b_err) begin
        n_checks++;
        if (qb.size() == 0) begin
          n_fail++;
          $display("FAIL b_unexpected_output cyc=%0d vld=%0b err=%0b data=%h required none", cyc, b_vld, b_err, b_rdata);
        end else begin
          eb = qb.pop_front();
          if (eb.cyc != cyc || b_err !== eb.err || b_vld !== !eb.err || (!eb.err && b_rdata !== eb.data)) begin
            n_fail++;
            $display("FAIL b_return cyc=%0d vld=%0b err=%0b data=%h required cyc=%0d err=%0b data=%h",
                     cyc, b_vld, b_err, b_rdata, eb.cyc, eb.err, eb.data);
          end
        end
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 16; i++) ma[i] = 8'h00;
    for (int i = 0; i < 12; i++) mb[i] = 8'h00;
    ma[2] = 8'h43; ma[3] = 8'h20;
    mb[2] = 8'h43; mb[3] = 8'h20;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One request cycle on A; the model decides the expected outcome before the edge.
  task automatic a_op(input bit wr, input bit rd, input logic [3:0] addr, input logic [7:0] d);
    a_wr = wr; a_rd = rd; a_addr = addr; a_wd = d;
    if (wr) begin
      if (addr == 4'd2 || addr == 4'd3) qa.push_back('{cyc: cyc + 1, err: 1'b1, data: 8'h00});
      else ma[addr] = d;
    end else if (rd) begin
      qa.push_back('{cyc: cyc + 1, err: 1'b0, data: ma[addr]});
    end
    @(posedge clk);
    #1;
    a_wr = 1'b0; a_rd = 1'b0;
  endtask

  task automatic b_op(input bit wr, input bit rd, input logic [3:0] addr, input logic [7:0] d);
    b_wr = wr; b_rd = rd; b_addr = addr; b_wd = d;
    if (wr) begin
      if (addr >= 4'd12 || addr == 4'd2 || addr == 4'd3) qb.push_back('{cyc: cyc + 1, err: 1'b1, data: 8'h00});
      else mb[addr] = d;
    end else if (rd) begin
      if (addr >= 4'd12) qb.push_back('{cyc: cyc + 1, err: 1'b1, data: 8'h00});
      else qb.push_back('{cyc: cyc + 2, err: 1'b0, data: mb[addr]});
    end
    @(posedge clk);
    #1;
    b_wr = 1'b0; b_rd = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_wr = 1'b0; a_rd = 1'b0; a_addr = '0; a_wd = '0;
    b_wr = 1'b0; b_rd = 1'b0; b_addr = '0; b_wd = '0;
    model_reset();
    #23;
    n_checks++;
    if ({a_vld, a_err, a_chg, a_rdata} !== 14'd0) begin
      n_fail++;
      $display("FAIL reset_a_outputs vld=%0b err=%0b chg=%b rdata=%h required all zero", a_vld, a_err, a_chg, a_rdata);
    end
    n_checks++;
    if (a_regout !== 32'h20430000) begin
      n_fail++;
      $display("FAIL reset_a_regout got=%h required=20430000", a_regout);
    end
    n_checks++;
    if ({b_vld, b_err, b_chg, b_rdata} !== 14'd0 || b_regout !== 32'h20430000) begin
      n_fail++;
      $display("FAIL reset_b_state vld=%0b err=%0b chg=%b rdata=%h regout=%h required zeros and 20430000",
               b_vld, b_err, b_chg, b_rdata, b_regout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_read_reset_values();
    for (int i = 0; i < 4; i++) a_op(1'b0, 1'b1, 4'(i), 8'h00);
    idle(2);
    n_checks++;
    if (a_regout !== 32'h20430000) begin
      n_fail++;
      $display("FAIL rst_vals_regout got=%h required=20430000", a_regout);
    end
  endtask

  task automatic test_read_only_write();
    a_op(1'b1, 1'b0, 4'd3, 8'h32);
    n_checks++;
    if (a_chg !== 4'b0000 || a_regout[31:24] !== 8'h20) begin
      n_fail++;
      $display("FAIL ro_write chg=%b reg3=%h required chg=0000 reg3=20", a_chg, a_regout[31:24]);
    end
    a_op(1'b1, 1'b0, 4'd7, 8'h46);
    a_op(1'b0, 1'b1, 4'd7, 8'h00);
    idle(3);
    n_checks++;
    if (a_rdata !== 8'h46 || a_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL rdata_hold rdata=%h vld=%0b required rdata=46 vld=0", a_rdata, a_vld);
    end
  endtask

  task automatic test_cfg_changed();
    a_op(1'b1, 1'b0, 4'd1, 8'h3C);
    n_checks++;
    if (a_chg !== 4'b0010 || a_regout[15:8] !== 8'h3C) begin
      n_fail++;
      $display("FAIL cfg_changed_pulse chg=%b reg1=%h required chg=0010 reg1=3c", a_chg, a_regout[15:8]);
    end
    idle(1);
    n_checks++;
    if (a_chg !== 4'b0000) begin
      n_fail++;
      $display("FAIL cfg_changed_width chg=%b required 0000", a_chg);
    end
    a_op(1'b1, 1'b0, 4'd1, 8'h3C);
    n_checks++;
    if (a_chg !== 4'b0000) begin
      n_fail++;
      $display("FAIL cfg_changed_same_value chg=%b required 0000", a_chg);
    end
    a_op(1'b1, 1'b0, 4'd0, 8'h5A);
    n_checks++;
    if (a_chg !== 4'b0001 || a_regout !== 32'h20433C5A) begin
      n_fail++;
      $display("FAIL cfg_changed_reg0 chg=%b regout=%h required chg=0001 regout=20433c5a", a_chg, a_regout);
    end
  endtask

  task automatic test_write_priority();
    a_op(1'b1, 1'b1, 4'd5, 8'hA5);
    n_checks++;
    if (a_vld !== 1'b0 || a_err !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_priority vld=%0b err=%0b required vld=0 err=0", a_vld, a_err);
    end
    a_op(1'b0, 1'b1, 4'd5, 8'h00);
    idle(2);
  endtask

  task automatic test_back_to_back();
    b_op(1'b1, 1'b0, 4'd4, 8'h04);
    b_op(1'b1, 1'b0, 4'd5, 8'h05);
    b_op(1'b1, 1'b0, 4'd6, 8'h06);
    b_op(1'b0, 1'b1, 4'd4, 8'h00);
    b_op(1'b0, 1'b1, 4'd5, 8'h00);
    b_op(1'b0, 1'b1, 4'd6, 8'h00);
    b_op(1'b1, 1'b0, 4'd6, 8'h77);
    idle(3);
    b_op(1'b0, 1'b1, 4'd6, 8'h00);
    idle(3);
    b_op(1'b0, 1'b1, 4'd13, 8'h00);
    idle(2);
    b_op(1'b1, 1'b0, 4'd13, 8'h99);
    idle(3);
    n_checks++;
    if (b_rdata !== 8'h77) begin
      n_fail++;
      $display("FAIL b_bad_read_keeps_rdata rdata=%h required 77", b_rdata);
    end
    b_op(1'b1, 1'b0, 4'd0, 8'h11);
    n_checks++;
    if (b_chg !== 4'b0001 || b_regout !== 32'h20430011) begin
      n_fail++;
      $display("FAIL b_write_reg0 chg=%b regout=%h required chg=0001 regout=20430011", b_chg, b_regout);
    end
    idle(3);
  endtask

  task automatic test_reset_inflight();
    b_rd = 1'b1; b_addr = 4'd5;
    @(posedge clk);
    #1;
    b_rd = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (b_vld !== 1'b0 || b_rdata !== 8'h00 || b_regout !== 32'h20430000 || a_regout !== 32'h20430000) begin
      n_fail++;
      $display("FAIL reset_inflight_state b_vld=%0b b_rdata=%h b_regout=%h a_regout=%h required 0 00 20430000 20430000",
               b_vld, b_rdata, b_regout, a_regout);
    end
    #10;
    rst_n = 1'b1;
    idle(4);
    b_op(1'b0, 1'b1, 4'd5, 8'h00);
    a_op(1'b0, 1'b1, 4'd1, 8'h00);
    idle(3);
  endtask

  initial begin
    test_reset();
    test_read_reset_values();
    test_read_only_write();
    test_cfg_changed();
    test_write_priority();
    test_back_to_back();
    test_reset_inflight();
    idle(3);
    n_checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drained a_left=%0d b_left=%0d required 0 0", qa.size(), qb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
